// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi_lite_pkg;

    // Command-engine states; one transaction in flight at a time.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_RESP  = 3'd2,
        RD_REQ   = 3'd3,
        RD_RESP  = 3'd4,
        RSP_OUT  = 3'd5
    } state_t;

    // AXI response codes, passed through unmodified to the response stream.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_resp_timer.sv
// Saturating wait counter for the B/R response phase; flags expiry when the
// count reaches TIMEOUT_CYCLES. A zero TIMEOUT_CYCLES removes the counter.
module axi_lite_resp_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear, run};
            assign expired       = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                                         $clog2(TIMEOUT_CYCLES + 1) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            // Next count: clear on phase entry, otherwise count up and stick at LIMIT.
            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (run && (count_q != LIMIT)) begin
                    count_d = count_q + CW'(1);
                end else begin
                    count_d = count_q;
                end
            end

            // Counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = run && (count_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master engine: turns one valid/ready command into a single
// AXI4-Lite read or write and returns the outcome on a response stream.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_if.master              axi,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state_q,       state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,      awaddr_d;
    logic                    awvalid_q,     awvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q,       wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,       wstrb_d;
    logic                    wvalid_q,      wvalid_d;
    logic                    bready_q,      bready_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,      araddr_d;
    logic                    arvalid_q,     arvalid_d;
    logic                    rready_q,      rready_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic [1:0]              rsp_resp_q,    rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic timer_clear_s;
    logic timer_run_s;
    logic timer_expired_s;
    logic aw_done_s;
    logic w_done_s;

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign timer_run_s = (state_q == WR_RESP) || (state_q == RD_RESP);

    // An address/data phase is finished once its VALID has been accepted,
    // either in this cycle or in an earlier one (VALID already dropped).
    assign aw_done_s = !awvalid_q || axi.awready;
    assign w_done_s  = !wvalid_q  || axi.wready;

    axi_lite_resp_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_resp_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .run     (timer_run_s),
        .expired (timer_expired_s)
    );

    // Next-state and next-output decode for the command engine.
    always_comb begin
        state_d       = state_q;
        awaddr_d      = awaddr_q;
        awvalid_d     = awvalid_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        araddr_d      = araddr_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clear_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WR_REQ: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_done_s && w_done_s) begin
                    bready_d      = 1'b1;
                    timer_clear_s = 1'b1;
                    state_d       = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end

            WR_RESP: begin
                if (axi.bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = axi.bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP_OUT;
                end else if (timer_expired_s) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP_OUT;
                end else begin
                    state_d = WR_RESP;
                end
            end

            RD_REQ: begin
                if (axi.arready) begin
                    arvalid_d     = 1'b0;
                    rready_d      = 1'b1;
                    timer_clear_s = 1'b1;
                    state_d       = RD_RESP;
                end else begin
                    state_d = RD_REQ;
                end
            end

            RD_RESP: begin
                if (axi.rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = axi.rdata;
                    rsp_resp_d    = axi.rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP_OUT;
                end else if (timer_expired_s) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP_OUT;
                end else begin
                    state_d = RD_RESP;
                end
            end

            RSP_OUT: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RSP_OUT;
                end
            end

            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, request and response registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            awaddr_q      <= '0;
            awvalid_q     <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            awaddr_q      <= awaddr_d;
            awvalid_q     <= awvalid_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            araddr_q      <= araddr_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a hand-driven AXI slave.
module tb_axi_lite_cmd_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;

    int checks_n;
    int fails_n;

    axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_bus ();

    axi_lite_cmd_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi         (axi_bus),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_n++;
        if (got !== exp) begin
            fails_n++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
    endtask

    initial begin
        int first_seen;
        int second_seen;
        checks_n = 0;
        fails_n  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.bresp   = 2'b00;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rdata   = 32'h0;

        // ---- reset state ----
        repeat (3) tick();
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_awvalid",   64'(axi_bus.awvalid), 64'd0);
        check_eq("rst_wvalid",    64'(axi_bus.wvalid), 64'd0);
        check_eq("rst_arvalid",   64'(axi_bus.arvalid), 64'd0);
        check_eq("rst_bready",    64'(axi_bus.bready), 64'd0);
        check_eq("rst_rready",    64'(axi_bus.rready), 64'd0);
        check_eq("rst_awaddr",    64'(axi_bus.awaddr), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // ---- write, both READYs high, 1-cycle B ----
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b1;
        put_cmd(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check_eq("wr_awvalid_n1", 64'(axi_bus.awvalid), 64'd1);
        check_eq("wr_wvalid_n1",  64'(axi_bus.wvalid), 64'd1);
        check_eq("wr_awaddr",     64'(axi_bus.awaddr), 64'h4);
        check_eq("wr_wdata",      64'(axi_bus.wdata), 64'h1234_5678);
        check_eq("wr_wstrb",      64'(axi_bus.wstrb), 64'hF);
        check_eq("wr_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        tick();
        check_eq("wr_awvalid_n2", 64'(axi_bus.awvalid), 64'd0);
        check_eq("wr_wvalid_n2",  64'(axi_bus.wvalid), 64'd0);
        check_eq("wr_bready_n2",  64'(axi_bus.bready), 64'd1);
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = 2'b00;
        tick();
        axi_bus.bvalid = 1'b0;
        check_eq("wr_rsp_valid_n3", 64'(rsp_valid), 64'd1);
        check_eq("wr_rsp_resp",     64'(rsp_resp), 64'd0);
        check_eq("wr_rsp_timeout",  64'(rsp_timeout), 64'd0);
        check_eq("wr_rsp_rdata",    64'(rsp_rdata), 64'd0);
        check_eq("wr_bready_drop",  64'(axi_bus.bready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("wr_rsp_valid_clr", 64'(rsp_valid), 64'd0);
        check_eq("wr_cmd_ready_back", 64'(cmd_ready), 64'd1);

        // ---- skewed AW/W: AWREADY 3 cycles late, WREADY immediate ----
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b1;
        put_cmd(1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 4'b0011);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        check_eq("skew_wvalid_first", 64'(axi_bus.wvalid), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("skew_wvalid_low",  64'(axi_bus.wvalid), 64'd0);
            check_eq("skew_awvalid_hold", 64'(axi_bus.awvalid), 64'd1);
            check_eq("skew_bready_wait", 64'(axi_bus.bready), 64'd0);
            check_eq("skew_awaddr_stable", 64'(axi_bus.awaddr), 64'h10);
            check_eq("skew_wdata_stable", 64'(axi_bus.wdata), 64'hA5A5_0F0F);
            check_eq("skew_wstrb_stable", 64'(axi_bus.wstrb), 64'h3);
        end
        axi_bus.awready = 1'b1;
        tick();
        check_eq("skew_awvalid_drop", 64'(axi_bus.awvalid), 64'd0);
        check_eq("skew_bready_up",    64'(axi_bus.bready), 64'd1);
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = 2'b01;
        tick();
        axi_bus.bvalid = 1'b0;
        check_eq("skew_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("skew_rsp_resp",  64'(rsp_resp), 64'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- read with DECERR after 5 cycles ----
        axi_bus.arready = 1'b1;
        put_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        check_eq("rd_arvalid", 64'(axi_bus.arvalid), 64'd1);
        check_eq("rd_araddr",  64'(axi_bus.araddr), 64'h8);
        check_eq("rd_no_awvalid", 64'(axi_bus.awvalid), 64'd0);
        tick();
        check_eq("rd_arvalid_drop", 64'(axi_bus.arvalid), 64'd0);
        check_eq("rd_rready_up",    64'(axi_bus.rready), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("rd_rready_wait", 64'(axi_bus.rready), 64'd1);
            check_eq("rd_rsp_wait",    64'(rsp_valid), 64'd0);
        end
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = 32'hDEAD_BEEF;
        axi_bus.rresp  = 2'b11;
        tick();
        axi_bus.rvalid = 1'b0;
        axi_bus.rdata  = 32'h0;
        check_eq("rd_rsp_valid",   64'(rsp_valid), 64'd1);
        check_eq("rd_rsp_rdata",   64'(rsp_rdata), 64'hDEAD_BEEF);
        check_eq("rd_rsp_resp",    64'(rsp_resp), 64'h3);
        check_eq("rd_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check_eq("rd_rready_drop", 64'(axi_bus.rready), 64'd0);

        // ---- response backpressure with a pending command ----
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b1;
        axi_bus.bvalid  = 1'b1;
        axi_bus.bresp   = 2'b00;
        put_cmd(1'b1, 32'h0000_0020, 32'h0000_0011, 4'hF);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("bp_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
            check_eq("bp_rsp_resp",  64'(rsp_resp), 64'h3);
            check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check_eq("bp_no_valid",  64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_rsp_valid_clr", 64'(rsp_valid), 64'd0);
        check_eq("bp_cmd_ready_k1",  64'(cmd_ready), 64'd1);

        // ---- back-to-back commands: cmd_ready every 4 cycles ----
        first_seen  = -1;
        second_seen = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (cmd_ready) begin
                if (first_seen < 0) begin
                    first_seen = i;
                end else if (second_seen < 0) begin
                    second_seen = i;
                end
            end
        end
        cmd_valid = 1'b0;
        check_eq("b2b_first_gap",  64'(first_seen), 64'd4);
        check_eq("b2b_second_gap", 64'(second_seen), 64'd8);
        axi_bus.bvalid = 1'b0;
        rsp_ready      = 1'b0;
        tick();
        check_eq("b2b_idle", 64'(axi_bus.awvalid), 64'd0);

        // ---- timeout: BVALID never comes ----
        put_cmd(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check_eq("to_awvalid", 64'(axi_bus.awvalid), 64'd1);
        tick();
        check_eq("to_bready_up", 64'(axi_bus.bready), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("to_bready_hold", 64'(axi_bus.bready), 64'd1);
            check_eq("to_rsp_wait",    64'(rsp_valid), 64'd0);
        end
        tick();
        check_eq("to_bready_drop", 64'(axi_bus.bready), 64'd0);
        check_eq("to_rsp_valid",   64'(rsp_valid), 64'd1);
        check_eq("to_rsp_resp",    64'(rsp_resp), 64'h2);
        check_eq("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
        check_eq("to_rsp_rdata",   64'(rsp_rdata), 64'd0);
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = 2'b00;
        repeat (2) tick();
        check_eq("to_late_b_resp",   64'(rsp_resp), 64'h2);
        check_eq("to_late_b_bready", 64'(axi_bus.bready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("to_cmd_ready_back", 64'(cmd_ready), 64'd1);
        tick();
        axi_bus.bvalid = 1'b0;
        check_eq("to_late_b_ignored", 64'(rsp_valid), 64'd0);

        // ---- reset while AW/W pending ----
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        put_cmd(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check_eq("mr_awvalid_before", 64'(axi_bus.awvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mr_awvalid_async", 64'(axi_bus.awvalid), 64'd0);
        check_eq("mr_wvalid_async",  64'(axi_bus.wvalid), 64'd0);
        check_eq("mr_ready_async",   64'({axi_bus.bready, axi_bus.rready}), 64'd0);
        check_eq("mr_rsp_valid",     64'(rsp_valid), 64'd0);
        check_eq("mr_cmd_ready_rst", 64'(cmd_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("mr_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check_eq("mr_awaddr_cleared",  64'(axi_bus.awaddr), 64'd0);
        check_eq("mr_awvalid_after",   64'(axi_bus.awvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
